// File: rtl/cajero_atm_param.sv
// Parametrised ATM session controller: PIN entry with lockout, deposits/withdrawals, card-removal abort.
// Optional inactivity timeout is built only when ATM_TIMEOUT_EN is defined.
module cajero_atm_param #(
    parameter int unsigned     PIN_DIGITS     = 4,
    parameter int unsigned     DIGIT_W        = 4,
    parameter int unsigned     MONTO_W        = 32,
    parameter int unsigned     BALANCE_W      = 32,
    parameter int unsigned     MAX_INTENTOS   = 3,
    parameter longint unsigned BAL_INIT       = 0,
    parameter int unsigned     TIMEOUT_CICLOS = 64
) (
    input  logic                            CLK,
    input  logic                            Reset,
    input  logic                            Tarjeta_recibida,
    input  logic [PIN_DIGITS*DIGIT_W-1:0]   PIN,
    input  logic [DIGIT_W-1:0]              Digito,
    input  logic                            Digito_STB,
    input  logic                            Tipo_trans,
    input  logic [MONTO_W-1:0]              Monto,
    input  logic                            Monto_STB,
    output logic [BALANCE_W-1:0]            Balance,
    output logic                            Balance_actualizado,
    output logic                            Entregar_dinero,
    output logic                            Fondos_insuficientes,
    output logic                            PIN_incorrecto,
    output logic                            Advertencia,
    output logic                            Bloqueo
);

    localparam int unsigned PIN_W = PIN_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int unsigned ATT_W = $clog2(MAX_INTENTOS + 1);

    typedef enum logic [2:0] {
        ESPERA_TARJETA, INGRESO_PIN, COMPARAR, SESION, BLOQUEO
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      dig_cnt, dig_cnt_d;
    logic [PIN_W-1:0]      entry, entry_d;
    logic [ATT_W-1:0]      attempts, attempts_d;
    logic [BALANCE_W-1:0]  balance_d;
    logic                  upd_d, ent_d, fi_d, pin_inc_d, adv_d, bloq_d;
    logic                  dig_stb_q, mon_stb_q;
    logic                  dig_ev, mon_ev;
    logic                  timeout_c, rearm_c;
    logic [BALANCE_W:0]    suma;
    logic [BALANCE_W-1:0]  monto_ext;

    // Rising-edge detection: a held strobe yields a single event.
    assign dig_ev = Digito_STB & ~dig_stb_q;
    assign mon_ev = Monto_STB & ~mon_stb_q;

`ifdef ATM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CICLOS + 1);
    logic [TO_W-1:0] to_cnt;
    logic            rearm;
    logic            activo;

    assign activo    = (state_q == INGRESO_PIN) || (state_q == SESION);
    assign timeout_c = activo && (to_cnt == TO_W'(TIMEOUT_CICLOS - 1));
    assign rearm_c   = rearm;

    // After a timeout the card must be seen removed before a new session starts.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            to_cnt <= '0;
            rearm  <= 1'b0;
        end else begin
            if (!activo || (state_d != state_q) || dig_ev || mon_ev)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);
            if (timeout_c)
                rearm <= 1'b1;
            else if (!Tarjeta_recibida)
                rearm <= 1'b0;
        end
    end
`else
    assign timeout_c = 1'b0 & (TIMEOUT_CICLOS != 0);
    assign rearm_c   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_q <= ESPERA_TARJETA;
        else       state_q <= state_d;
    end

    // Next state: card removal outranks timeout, which outranks strobe events.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ESPERA_TARJETA: if (Tarjeta_recibida && !rearm_c) state_d = INGRESO_PIN;
            INGRESO_PIN: begin
                if (!Tarjeta_recibida || timeout_c)
                    state_d = ESPERA_TARJETA;
                else if (dig_ev && (dig_cnt == CNT_W'(PIN_DIGITS - 1)))
                    state_d = COMPARAR;
            end
            COMPARAR: begin
                if (!Tarjeta_recibida)
                    state_d = ESPERA_TARJETA;
                else if (entry == PIN)
                    state_d = SESION;
                else if ((attempts + ATT_W'(1)) == ATT_W'(MAX_INTENTOS))
                    state_d = BLOQUEO;
                else
                    state_d = INGRESO_PIN;
            end
            SESION:  if (!Tarjeta_recibida || timeout_c) state_d = ESPERA_TARJETA;
            BLOQUEO: state_d = BLOQUEO;
            default: state_d = ESPERA_TARJETA;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        dig_cnt_d  = '0;
        entry_d    = entry;
        attempts_d = attempts;
        balance_d  = Balance;
        upd_d      = 1'b0;
        ent_d      = 1'b0;
        fi_d       = 1'b0;
        pin_inc_d  = 1'b0;
        suma       = {1'b0, Balance} + (BALANCE_W + 1)'(Monto);
        monto_ext  = BALANCE_W'(Monto);
        case (state_q)
            INGRESO_PIN: begin
                if (state_d == INGRESO_PIN || state_d == COMPARAR) begin
                    dig_cnt_d = dig_cnt;
                    if (dig_ev) begin
                        entry_d   = PIN_W'({entry, Digito});
                        dig_cnt_d = dig_cnt + CNT_W'(1);
                    end
                end
            end
            COMPARAR: begin
                if (Tarjeta_recibida) begin
                    if (entry == PIN) begin
                        attempts_d = '0;
                    end else begin
                        pin_inc_d  = 1'b1;
                        attempts_d = attempts + ATT_W'(1);
                    end
                end
            end
            SESION: begin
                if (state_d == SESION && mon_ev) begin
                    if (!Tipo_trans) begin
                        balance_d = suma[BALANCE_W] ? '1 : suma[BALANCE_W-1:0];
                        upd_d     = 1'b1;
                    end else if (monto_ext <= Balance) begin
                        balance_d = Balance - monto_ext;
                        upd_d     = 1'b1;
                        ent_d     = 1'b1;
                    end else begin
                        fi_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        adv_d  = (state_d != BLOQUEO) && (attempts_d == ATT_W'(MAX_INTENTOS - 1));
        bloq_d = (state_d == BLOQUEO);
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            dig_stb_q            <= 1'b0;
            mon_stb_q            <= 1'b0;
            dig_cnt              <= '0;
            entry                <= '0;
            attempts             <= '0;
            Balance              <= BALANCE_W'(BAL_INIT);
            Balance_actualizado  <= 1'b0;
            Entregar_dinero      <= 1'b0;
            Fondos_insuficientes <= 1'b0;
            PIN_incorrecto       <= 1'b0;
            Advertencia          <= 1'b0;
            Bloqueo              <= 1'b0;
        end else begin
            dig_stb_q            <= Digito_STB;
            mon_stb_q            <= Monto_STB;
            dig_cnt              <= dig_cnt_d;
            entry                <= entry_d;
            attempts             <= attempts_d;
            Balance              <= balance_d;
            Balance_actualizado  <= upd_d;
            Entregar_dinero      <= ent_d;
            Fondos_insuficientes <= fi_d;
            PIN_incorrecto       <= pin_inc_d;
            Advertencia          <= adv_d;
            Bloqueo              <= bloq_d;
        end
    end

endmodule

// File: tb/tb_cajero_atm_param.sv
// Directed bench for cajero_atm_param: a default instance (PIN F000) and an 8-bit instance
// (BAL_INIT=250, PIN 1234) share keypad/amount inputs; each has its own card signal.
module tb_cajero_atm_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_a, card_b;
    logic [3:0]  digito;
    logic        digito_stb;
    logic        tipo;
    logic [31:0] monto;
    logic        monto_stb;

    logic [31:0] bal_a;
    logic        upd_a, ent_a, fi_a, pin_a, adv_a, bloq_a;
    logic [7:0]  bal_b;
    logic        upd_b, ent_b, fi_b, pin_b, adv_b, bloq_b;

    int n_cmp = 0;
    int n_bad = 0;
    int na_pin = 0, na_upd = 0, na_ent = 0, na_fi = 0;
    int nb_pin = 0, nb_upd = 0, nb_ent = 0, nb_fi = 0;

    always #5 clk = ~clk;

    cajero_atm_param #(.TIMEOUT_CICLOS(20)) dut (
        .CLK(clk), .Reset(rst), .Tarjeta_recibida(card_a), .PIN(16'hF000),
        .Digito(digito), .Digito_STB(digito_stb), .Tipo_trans(tipo),
        .Monto(monto), .Monto_STB(monto_stb), .Balance(bal_a),
        .Balance_actualizado(upd_a), .Entregar_dinero(ent_a),
        .Fondos_insuficientes(fi_a), .PIN_incorrecto(pin_a),
        .Advertencia(adv_a), .Bloqueo(bloq_a)
    );

    cajero_atm_param #(.BALANCE_W(8), .MONTO_W(8), .BAL_INIT(250)) dut8 (
        .CLK(clk), .Reset(rst), .Tarjeta_recibida(card_b), .PIN(16'h1234),
        .Digito(digito), .Digito_STB(digito_stb), .Tipo_trans(tipo),
        .Monto(monto[7:0]), .Monto_STB(monto_stb), .Balance(bal_b),
        .Balance_actualizado(upd_b), .Entregar_dinero(ent_b),
        .Fondos_insuficientes(fi_b), .PIN_incorrecto(pin_b),
        .Advertencia(adv_b), .Bloqueo(bloq_b)
    );

    // Pulses are counted per high cycle, so a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (pin_a === 1'b1) na_pin++;
        if (upd_a === 1'b1) na_upd++;
        if (ent_a === 1'b1) na_ent++;
        if (fi_a  === 1'b1) na_fi++;
        if (pin_b === 1'b1) nb_pin++;
        if (upd_b === 1'b1) nb_upd++;
        if (ent_b === 1'b1) nb_ent++;
        if (fi_b  === 1'b1) nb_fi++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d, input int hold);
        digito     = d;
        digito_stb = 1'b1;
        step(hold);
        digito_stb = 1'b0;
        step(1);
    endtask

    task automatic enter_pin(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3);
        press(d0, 1);
        press(d1, 1);
        press(d2, 1);
        press(d3, 1);
        step(2);
    endtask

    task automatic txn(input logic t, input logic [31:0] m, input int hold);
        tipo      = t;
        monto     = m;
        monto_stb = 1'b1;
        step(hold);
        monto_stb = 1'b0;
        step(2);
    endtask

    task automatic reinsert_a();
        card_a = 1'b0;
        step(2);
        card_a = 1'b1;
        step(2);
    endtask

    initial begin
        rst = 1'b1; card_a = 1'b0; card_b = 1'b0;
        digito = '0; digito_stb = 1'b0; tipo = 1'b0; monto = '0; monto_stb = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_bal", bal_a, 0);
        check("rst_bal8", bal_b, 250);
        check("rst_adv", adv_a, 0);
        check("rst_bloq", bloq_a, 0);
        check("rst_pulses", na_pin + na_upd + na_ent + na_fi, 0);

        // Three wrong PINs lead to lockout.
        card_a = 1'b1;
        step(2);
        enter_pin(4'h8, 4'h0, 4'h0, 4'h0);
        check("wrong1_pin", na_pin, 1);
        check("wrong1_adv", adv_a, 0);
        enter_pin(4'h4, 4'h0, 4'h0, 4'h0);
        check("wrong2_pin", na_pin, 2);
        check("wrong2_adv", adv_a, 1);
        check("wrong2_bloq", bloq_a, 0);
        enter_pin(4'h2, 4'h0, 4'h0, 4'h0);
        check("wrong3_pin", na_pin, 3);
        check("wrong3_bloq", bloq_a, 1);
        check("wrong3_adv", adv_a, 0);

        // Lockout ignores digits, amounts and card changes.
        enter_pin(4'hF, 4'h0, 4'h0, 4'h0);
        txn(1'b0, 63, 1);
        reinsert_a();
        enter_pin(4'hF, 4'h0, 4'h0, 4'h0);
        check("lock_pin", na_pin, 3);
        check("lock_upd", na_upd, 0);
        check("lock_bloq", bloq_a, 1);
        check("lock_bal", bal_a, 0);

        // Reset releases lockout; correct PIN opens a session.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        check("unlock_bloq", bloq_a, 0);
`ifndef ATM_TIMEOUT_EN
        step(30);
`endif
        enter_pin(4'hF, 4'h0, 4'h0, 4'h0);
        check("ok_pin", na_pin, 3);
        check("ok_adv", adv_a, 0);

        txn(1'b0, 63, 1);
        check("dep63_bal", bal_a, 63);
        check("dep63_upd", na_upd, 1);
        txn(1'b1, 31, 1);
        check("wd31_bal", bal_a, 32);
        check("wd31_ent", na_ent, 1);
        check("wd31_upd", na_upd, 2);
        txn(1'b1, 63, 1);
        check("wd63_fi", na_fi, 1);
        check("wd63_bal", bal_a, 32);
        check("wd63_upd", na_upd, 2);
        txn(1'b0, 0, 1);
        check("dep0_upd", na_upd, 3);
        check("dep0_bal", bal_a, 32);
        txn(1'b1, 32, 1);
        check("wdall_bal", bal_a, 0);
        check("wdall_ent", na_ent, 2);
        txn(1'b0, 5, 3);
        check("hold_bal", bal_a, 5);
        check("hold_upd", na_upd, 5);
        press(4'h1, 1);
        step(1);
        check("sess_dig_pin", na_pin, 3);

        // Card removal ends the session; amounts during PIN entry are ignored.
        reinsert_a();
        txn(1'b0, 7, 1);
        check("ingreso_mon_bal", bal_a, 5);
        enter_pin(4'hF, 4'h0, 4'h0, 4'h0);
        check("resess_pin", na_pin, 3);
        txn(1'b0, 1, 1);
        check("resess_bal", bal_a, 6);
        check("resess_upd", na_upd, 6);

        // Attempts survive card removal; partial PIN is discarded; held digit counts once.
        reinsert_a();
        enter_pin(4'h1, 4'h2, 4'h3, 4'h4);
        check("att1_pin", na_pin, 4);
        check("att1_adv", adv_a, 0);
        press(4'h5, 1);
        press(4'h6, 1);
        reinsert_a();
        press(4'h7, 3);
        press(4'h8, 1);
        press(4'h9, 1);
        press(4'hA, 1);
        step(2);
        check("att2_pin", na_pin, 5);
        check("att2_adv", adv_a, 1);
        check("att2_bloq", bloq_a, 0);
        enter_pin(4'hF, 4'h0, 4'h0, 4'h0);
        check("att_ok_pin", na_pin, 5);
        check("att_ok_adv", adv_a, 0);
        txn(1'b0, 4, 1);
        check("att_ok_bal", bal_a, 10);

        // Reset mid-transaction clears the balance.
        tipo = 1'b0; monto = 100; monto_stb = 1'b1; rst = 1'b1;
        step(1);
        rst = 1'b0; monto_stb = 1'b0;
        step(2);
        check("rst_mid_bal", bal_a, 0);
        check("rst_mid_upd", na_upd, 7);

        // 8-bit instance: saturating deposit and exact full withdrawal.
        card_a = 1'b0;
        card_b = 1'b1;
        step(2);
        enter_pin(4'h1, 4'h2, 4'h3, 4'h4);
        check("b_pin", nb_pin, 0);
        txn(1'b0, 10, 1);
        check("b_sat_bal", bal_b, 255);
        check("b_sat_upd", nb_upd, 1);
        txn(1'b1, 255, 1);
        check("b_wd_bal", bal_b, 0);
        check("b_wd_ent", nb_ent, 1);
        txn(1'b1, 1, 1);
        check("b_fi", nb_fi, 1);
        check("b_fi_bal", bal_b, 0);
        card_b = 1'b0;

`ifdef ATM_TIMEOUT_EN
        // Idle session times out; re-entry needs the card toggled.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        card_a = 1'b1;
        step(25);
        enter_pin(4'hF, 4'h0, 4'h0, 4'h0);
        txn(1'b0, 9, 1);
        check("to_bal", bal_a, 0);
        check("to_upd", na_upd, 7);
        reinsert_a();
        enter_pin(4'hF, 4'h0, 4'h0, 4'h0);
        txn(1'b0, 9, 1);
        check("to_re_bal", bal_a, 9);
        check("to_re_upd", na_upd, 8);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cajero_atm_param.md
Name: cajero_atm_param

Overview:
- Parametrised ATM session controller that supersedes the fixed 4-digit / 3-attempt controller.
- PIN length, digit width, amount and balance widths, and the attempt limit are all parameters.
- Adds a readable balance output, saturating deposits and card-removal abort.
- Connects to the same keypad, card-reader and cash-dispenser signals as the existing probador bench.

Parameters:
- PIN_DIGITS, 4: number of digits per PIN entry.
- DIGIT_W, 4: bits per digit.
- MONTO_W, 32: transaction amount width.
- BALANCE_W, 32: balance register width; must satisfy BALANCE_W >= MONTO_W.
- MAX_INTENTOS, 3: wrong PIN entries that cause lockout; must be >= 2.
- BAL_INIT, 0: balance value loaded on reset.
- TIMEOUT_CICLOS, 64: inactivity limit in clock cycles; used only with ATM_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
- Tarjeta_recibida  in  1  card present (level).
- PIN  in  PIN_DIGITS*DIGIT_W  stored PIN; most significant digit is entered first.
- Digito  in  DIGIT_W  keypad digit.
- Digito_STB  in  1  digit strobe.
- Tipo_trans  in  1  0 = deposit, 1 = withdrawal.
- Monto  in  MONTO_W  transaction amount.
- Monto_STB  in  1  amount strobe.
- Balance  out  BALANCE_W  current balance.
- Balance_actualizado  out  1  one-cycle pulse: balance changed.
- Entregar_dinero  out  1  one-cycle pulse: dispense cash.
- Fondos_insuficientes  out  1  one-cycle pulse: withdrawal refused.
- PIN_incorrecto  out  1  one-cycle pulse: wrong PIN.
- Advertencia  out  1  level: one attempt remaining.
- Bloqueo  out  1  level: locked out.

Behaviour:
- **Reset values:**
  - All pulse outputs, Advertencia and Bloqueo = 0.
  - Balance = BAL_INIT; attempt counter = 0; digit counter = 0.
  - State = ESPERA_TARJETA.
- **Strobe detection:**
  - Digito_STB and Monto_STB are registered.
  - An event is sampled 1 with previous sample 0.
  - A strobe held high for N cycles counts as one event.
  - Digit and Monto/Tipo_trans are captured on the event cycle.
- **ESPERA_TARJETA:** Tarjeta_recibida=1 -> INGRESO_PIN; digit counter cleared.
- **INGRESO_PIN:**
  - Each Digito_STB event shifts Digito into the entry register and increments the digit counter.
  - On the PIN_DIGITS-th event -> COMPARAR.
  - Monto_STB is ignored.
- **COMPARAR (1 cycle):** compares the full entry register against PIN sampled this cycle.
  - Match: attempt counter = 0, Advertencia = 0 -> SESION.
  - Mismatch: PIN_incorrecto pulses this cycle and the attempt counter increments.
    - If the count reaches MAX_INTENTOS: -> BLOQUEO.
    - Otherwise: -> INGRESO_PIN with the digit counter cleared.
  - Advertencia is a registered level equal to (attempts == MAX_INTENTOS-1).
  - Result latency: pulse and state change appear on the cycle after the final digit event.
- **SESION:** each Monto_STB event is one transaction; Digito_STB is ignored.
  - Deposit: Balance += Monto, saturating at 2^BALANCE_W-1; Balance_actualizado pulses. A zero deposit still pulses.
  - Withdrawal, Monto <= Balance: Balance -= Monto; Balance_actualizado and Entregar_dinero pulse in the same cycle. Monto == Balance is allowed and leaves Balance = 0.
  - Withdrawal, Monto > Balance: Fondos_insuficientes pulses; Balance is unchanged.
  - Balance updates and pulses are registered one cycle after the strobe event.
- **BLOQUEO:**
  - Bloqueo = 1 and Advertencia = 0.
  - All strobes and card changes are ignored.
  - Only Reset exits.
- **Card removal:**
  - Tarjeta_recibida=0 in INGRESO_PIN, COMPARAR or SESION -> ESPERA_TARJETA.
  - The partial PIN is discarded.
  - The attempt counter and Balance are retained; removing the card never resets attempts.
- **Simultaneous events:**
  - Card removal has priority over a strobe event in the same cycle; the strobe is dropped.
  - Reset has priority over everything, acts immediately, and clears Balance mid-transaction.

Optional Feature:
- Macro ATM_TIMEOUT_EN.
- **Defined:**
  - An inactivity counter runs in INGRESO_PIN and SESION.
  - It clears on any strobe event or state change.
  - On reaching TIMEOUT_CICLOS: -> ESPERA_TARJETA, partial PIN discarded, attempts and Balance retained.
  - Re-entry requires Tarjeta_recibida to be seen 0 and then 1 again.
- **Undefined:**
  - No counter is built; TIMEOUT_CICLOS is unused.
  - Sessions never time out.

Test Plan:
- Defaults, PIN=16'hF000; enter 8,0,0,0 / 4,0,0,0 / 2,0,0,0 -> PIN_incorrecto pulses 3 times; Advertencia=1 after the 2nd pulse; Bloqueo=1 after the 3rd; further strobes have no effect.
- Reset during Bloqueo, card in, enter F,0,0,0 -> no PIN_incorrecto; SESION entered; Advertencia=0.
- BAL_INIT=0: deposit 63 -> Balance=63, Balance_actualizado pulse; withdraw 31 -> Balance=32 with Entregar_dinero pulse; withdraw 63 -> Fondos_insuficientes pulse, Balance=32.
- BALANCE_W=8, MONTO_W=8, BAL_INIT=250: deposit 10 -> Balance=255 (saturated); withdraw 255 -> Balance=0, Entregar_dinero pulse.
- One wrong PIN, card removed after 2 digits, card reinserted, one more wrong PIN -> attempts=2, Advertencia=1; Digito_STB held 3 cycles counts as 1 digit.
- ATM_TIMEOUT_EN, TIMEOUT_CICLOS=20: card in, no strobes for 20 cycles -> ESPERA_TARJETA; strobes ignored until the card toggles 0->1.
